// File: rtl/spram_ctrl_pkg.sv
// rtl/spram_ctrl_pkg.sv - shared widths and FSM state encoding for the SPRAM burst controller
package spram_ctrl_pkg;

  localparam int AWIDTH_DEF = 12;
  localparam int DWIDTH_DEF = 60;
  localparam int LWIDTH_DEF = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spram_rd_fifo2.sv
// rtl/spram_rd_fifo2.sv - 2-entry first-word-fall-through FIFO holding read return data
module spram_rd_fifo2
  import spram_ctrl_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_pop_data,
  output logic              o_empty,
  output logic [1:0]        o_count
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop      = i_pop && (r_count != 2'd0);
  assign w_push     = i_push && ((r_count != 2'd2) || w_pop);
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == 2'd0);
  assign o_count    = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream credit check must make a push into a full FIFO impossible.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: rtl/spram_burst_ctrl.sv
// rtl/spram_burst_ctrl.sv - turns one burst command into single-port RAM cycles, streaming write data in and read data out
module spram_burst_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LWIDTH = LWIDTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [AWIDTH-1:0] i_cmd_addr,
  input  logic [LWIDTH-1:0] i_cmd_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DWIDTH-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DWIDTH-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [AWIDTH-1:0] o_ram_address,
  output logic              o_ram_wren,
  output logic [DWIDTH-1:0] o_ram_data,
  input  logic [DWIDTH-1:0] i_ram_out
);

  state_t            r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH-1:0] r_last_addr;
  logic [LWIDTH-1:0] r_rem;
  logic              r_rd_pend;
  logic              r_cmd_ready;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_wr_fire;
  logic              w_issue;
  logic              w_pop;
  logic              w_empty;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_credit;

  assign w_pop     = !w_empty && i_out_ready;
  assign w_wr_fire = r_in_ready && i_in_valid;
  // A slot popped this cycle counts as free, otherwise a full-rate reader stalls every other clk.
  assign w_credit  = {1'b0, w_fifo_count} - {2'b00, w_pop} + {2'b00, r_rd_pend};
  assign w_issue   = (r_state == ST_READ) && (w_credit < 3'd2);

  assign o_ram_wren    = w_wr_fire;
  assign o_ram_address = (w_wr_fire || w_issue) ? r_addr : r_last_addr;
  assign o_ram_data    = w_wr_fire ? i_in_data : '0;
  assign o_cmd_ready   = r_cmd_ready;
  assign o_in_ready    = r_in_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_out_valid   = !w_empty;

  spram_rd_fifo2 #(
    .DWIDTH(DWIDTH)
  ) u_rd_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_resetn),
    .i_push      (r_rd_pend),
    .i_push_data (i_ram_out),
    .i_pop       (w_pop),
    .o_pop_data  (o_out_data),
    .o_empty     (w_empty),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_rem       <= '0;
      r_rd_pend   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_done    <= 1'b0;
      if (w_wr_fire || w_issue) begin
        r_last_addr <= r_addr;
        r_addr      <= r_addr + AWIDTH'(1);
        r_rem       <= r_rem - LWIDTH'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_addr      <= i_cmd_addr;
            r_rem       <= i_cmd_len;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (i_cmd_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (i_cmd_write) begin
              r_state    <= ST_WRITE;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (w_wr_fire && (r_rem == LWIDTH'(1))) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        ST_READ: begin
          if (w_issue && (r_rem == LWIDTH'(1))) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!r_rd_pend && w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_burst_ctrl.sv
// tb/tb_spram_burst_ctrl.sv - self-checking bench for spram_burst_ctrl with a behavioural RAM and memory model
module tb_spram_burst_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [12:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_data;
  logic        busy;
  logic        done;
  logic [11:0] ram_address;
  logic        ram_wren;
  logic [59:0] ram_data;
  logic [59:0] ram_out;

  logic [59:0] ram     [0:4095];
  logic [59:0] exp_mem [0:4095];

  int          total = 0;
  int          bad   = 0;
  logic [11:0] g_last;

  typedef struct {
    bit          w;
    logic [11:0] a;
    int          len;
    int          vprob;
    int          rmode;
    logic [59:0] pat;
    int          exp_first;
    int          exp_done;
    logic [11:0] exp_last;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  spram_burst_ctrl dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_write   (cmd_write),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_len     (cmd_len),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_data     (in_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_busy        (busy),
    .o_done        (done),
    .o_ram_address (ram_address),
    .o_ram_wren    (ram_wren),
    .o_ram_data    (ram_data),
    .i_ram_out     (ram_out)
  );

  always @(posedge clk) begin
    if (ram_wren) ram[ram_address] <= ram_data;
    ram_out <= ram[ram_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_burst(input bit w, input logic [11:0] a, input int len, input int vprob,
                           input int rmode, input logic [59:0] pat, input bit junk,
                           input logic [11:0] exp_last,
                           output int first_cyc, output int last_cyc, output int done_cyc);
    logic [59:0] wq[$];
    logic [63:0] r64;
    logic [11:0] ea;
    int n_in, n_out, cyc, waitc;
    bit seen_done, busy_bad;
    n_in = 0; n_out = 0; cyc = 0; waitc = 0;
    seen_done = 0; busy_bad = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    for (int i = 0; i < len; i++) begin
      r64 = {$urandom, $urandom};
      wq.push_back((pat != '0) ? pat + 60'(i) : r64[59:0]);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 13'(len);
    @(negedge clk);
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    if (junk) begin
      cmd_write = !w; cmd_addr = 12'h777; cmd_len = 13'd1;
    end else begin
      cmd_valid = 1'b0;
    end
    while (!seen_done && cyc < len * 4 + 50) begin
      in_valid  = w && (n_in < len) && ($urandom_range(0, 99) < vprob);
      in_data   = in_valid ? wq[n_in] : '0;
      out_ready = (rmode == 200) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < rmode);
      @(negedge clk);
      if (in_valid || ram_wren) chk("wr_fire", ram_wren, in_valid);
      if (in_valid && ram_wren) begin
        ea = a + 12'(n_in);
        chk("wr_addr", ram_address, ea);
        chk("wr_data", ram_data, wq[n_in]);
        exp_mem[ea] = wq[n_in];
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (n_out >= len) begin
          chk("extra_out", n_out, len);
        end else begin
          ea = a + 12'(n_out);
          chk("rd_data", out_data, exp_mem[ea]);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
      if (!busy || cmd_ready) busy_bad = 1;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cmd_valid = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("word_count", w ? n_in : n_out, len);
    chk("busy_during", busy_bad, 0);
    chk("idle_after", {done, busy, cmd_ready, out_valid, ram_wren}, 5'b00100);
    chk("idle_addr", ram_address, exp_last);
    chk("idle_data", ram_data, 0);
  endtask

  initial begin
    int fc, lc, dc, nbad;
    bit rw;
    logic [11:0] ra, el;
    int rl;

    for (int i = 0; i < 4096; i++) begin
      ram[i] <= '0;
      exp_mem[i] = '0;
    end
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    g_last = '0;

    //          w     addr     len  vprob rmode pat      first done  last
    tbl[0] = '{1'b1, 12'h010, 4,    100,  100,  60'hA0,  0,    4,    12'h013};
    tbl[1] = '{1'b0, 12'h010, 4,    100,  100,  60'h0,   2,    7,    12'h013};
    tbl[2] = '{1'b0, 12'h010, 8,    100,  200,  60'h0,   -1,   -1,   12'h017};
    tbl[3] = '{1'b1, 12'hFFE, 4,    100,  100,  60'h550, 0,    4,    12'h001};
    tbl[4] = '{1'b0, 12'hFFE, 4,    100,  100,  60'h0,   2,    7,    12'h001};
    tbl[5] = '{1'b1, 12'hF00, 300,  70,   100,  60'h0,   -1,   -1,   12'h02B};
    tbl[6] = '{1'b0, 12'hF00, 300,  100,  60,   60'h0,   -1,   -1,   12'h02B};
    tbl[7] = '{1'b1, 12'h123, 4100, 100,  100,  60'h0,   0,    4100, 12'h126};
    tbl[8] = '{1'b0, 12'h120, 10,   100,  100,  60'h0,   2,    13,   12'h129};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {cmd_ready, in_ready, out_valid, busy, done, ram_wren}, 6'b100000);
    chk("reset_addr", ram_address, 0);
    chk("reset_ram_data", ram_data, 0);
    chk("reset_out_data", out_data, 0);
    @(posedge clk); #1 resetn = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_burst(tbl[k].w, tbl[k].a, tbl[k].len, tbl[k].vprob, tbl[k].rmode, tbl[k].pat, 1'b0,
                tbl[k].exp_last, fc, lc, dc);
      g_last = tbl[k].exp_last;
      if (tbl[k].exp_first >= 0) begin
        chk("first_cyc", fc, tbl[k].exp_first);
        chk("burst_span", lc - fc, tbl[k].len - 1);
      end
      if (tbl[k].exp_done >= 0) chk("done_cyc", dc, tbl[k].exp_done);
    end

    run_burst(1'b1, 12'h300, 0, 100, 100, 60'h0, 1'b0, g_last, fc, lc, dc);
    chk("len0_done_lat", (dc >= 0) && (dc <= 2), 1);
    chk("len0_no_access", fc, -1);

    run_burst(1'b1, 12'h400, 6, 100, 100, 60'h5A0, 1'b1, 12'h405, fc, lc, dc);
    g_last = 12'h405;
    chk("busy_cmd_first", fc, 0);
    chk("busy_cmd_done", dc, 6);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 13'd4; out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("buffered_valid", out_valid, 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_flags", {out_valid, cmd_ready, busy, done}, 4'b0100);
    @(posedge clk); #1 resetn = 1'b1;
    g_last = '0;
    nbad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || out_valid) nbad++;
    end
    chk("no_done_after_rst", nbad, 0);
    @(posedge clk); #1;
    run_burst(1'b0, 12'h010, 4, 100, 100, 60'h0, 1'b0, 12'h013, fc, lc, dc);
    g_last = 12'h013;
    chk("post_rst_first", fc, 2);
    chk("post_rst_done", dc, 7);

    for (int k = 0; k < 24; k++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 12'($urandom_range(0, 4095));
      rl = $urandom_range(0, 40);
      el = (rl > 0) ? ra + 12'(rl - 1) : g_last;
      run_burst(rw, ra, rl, $urandom_range(30, 100), $urandom_range(30, 100), 60'h0, 1'b0,
                el, fc, lc, dc);
      g_last = el;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
